mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the pipeline's instruction fetch (IF) and data memory (MEM-stage load/store) requesters.
- Sequences each access with a req/ack handshake and returns read data to the owning requester.
- Drives a stall to the pipeline while any access is outstanding.
- Bounds every access with a timeout and records a sticky error.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester and memory-side signals of mem_port_arbiter.
//   master : arbiter view (takes requests and mem_rdata/mem_ack, drives done/rdata/mem_*/stall)
//   slave  : environment view (pipeline requesters plus memory)
interface mem_port_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) ();
   // Instruction fetch requester
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_done;
   // Data (load/store) requester
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_done;
   // Unified memory port
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   // Pipeline stall
   logic          stall;

   modport master (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      output if_rdata, if_done, dm_rdata, dm_done, mem_req, mem_we, mem_addr, mem_wdata, stall
   );

   modport slave (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_done, dm_rdata, dm_done, mem_req, mem_we, mem_addr, mem_wdata, stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (if) and data access (dm).
// Each access is a req/ack handshake on the mem_* port, bounded by a TIMEOUT-cycle wait;
// a timeout aborts the access, returns all ones for reads and sets the sticky err flag.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : requester, memory and stall signals (master modport of mem_port_arbiter_if)
//   err   : sticky timeout flag, cleared only by reset
module mem_port_arbiter #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.master bus,
   output logic               err
);
   // Abort fires in the SERVE cycle whose count would reach TIMEOUT, so mem_req is high for
   // at most TIMEOUT cycles; an ack in that last cycle still wins.
   localparam logic [7:0] WaitLimit = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StServeDm, StServeIf} state_e;

   state_e        state_q, state_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] dm_rdata_q, dm_rdata_d;
   logic          if_done_q, if_done_d;
   logic          dm_done_q, dm_done_d;
   logic          err_q, err_d;
   logic [7:0]    wait_cnt_q, wait_cnt_d;

   logic          dm_eligible;
   logic          if_eligible;
   logic [DW-1:0] ret_data;

   // A requester whose done is high this cycle was just served; masking it here gives the
   // other side the mandatory post-access IDLE cycle and prevents starvation.
   assign dm_eligible = bus.dm_req & ~dm_done_q;
   assign if_eligible = bus.if_req & ~if_done_q;

   // Read data returned on completion: memory data on ack, all ones on timeout.
   assign ret_data = bus.mem_ack ? bus.mem_rdata : '1;

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_done_d   = 1'b0;
      dm_done_d   = 1'b0;
      err_d       = err_q;
      wait_cnt_d  = wait_cnt_q;

      case (state_q)
         StIdle: begin
            wait_cnt_d = '0;
            if (dm_eligible) begin
               mem_addr_d  = bus.dm_addr;
               mem_we_d    = bus.dm_we;
               mem_wdata_d = bus.dm_wdata;
               mem_req_d   = 1'b1;
               state_d     = StServeDm;
            end else if (if_eligible) begin
               mem_addr_d = bus.if_addr;
               mem_we_d   = 1'b0;
               mem_req_d  = 1'b1;
               state_d    = StServeIf;
            end
         end

         StServeDm, StServeIf: begin
            if (bus.mem_ack || (wait_cnt_q == WaitLimit)) begin
               state_d    = StIdle;
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               wait_cnt_d = '0;
               if (!bus.mem_ack) begin
                  err_d = 1'b1;
               end
               if (state_q == StServeIf) begin
                  if_done_d  = 1'b1;
                  if_rdata_d = ret_data;
               end else begin
                  dm_done_d = 1'b1;
                  // Stores leave the last load result untouched.
                  if (!mem_we_q) begin
                     dm_rdata_d = ret_data;
                  end
               end
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_done_q   <= 1'b0;
         dm_done_q   <= 1'b0;
         err_q       <= 1'b0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_done_q   <= if_done_d;
         dm_done_q   <= dm_done_d;
         err_q       <= err_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.dm_done   = dm_done_q;
   assign err           = err_q;

   // The stall drops in the done cycle even though req is still held high.
   assign bus.stall = (bus.if_req & ~if_done_q) | (bus.dm_req & ~dm_done_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single accesses, then hand-written
// sequences for simultaneous requests, fairness, idle acks and reset mid-access.
// Read data is checked through per-requester scoreboard queues popped on each done pulse.
module tb_mem_port_arbiter;
   localparam int unsigned TO = 15;

   logic clk;
   logic reset;
   logic err;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus),
      .err  (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory contents model.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a == 32'h40) ? 32'h8C22_0004 : {~a[15:0], a[15:0]};
   endfunction

   // Memory responder: acks after resp_wait wait cycles of mem_req; junk data when not acking.
   int   resp_wait = 0;
   bit   idle_ack  = 0;
   int   rcnt;
   initial begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      rcnt          = 0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.mem_req) begin
            bus.mem_ack   = (rcnt == resp_wait);
            bus.mem_rdata = (rcnt == resp_wait) ? word_at(bus.mem_addr) : 32'hBAD0_BAD0;
            rcnt++;
         end else begin
            rcnt          = 0;
            bus.mem_ack   = idle_ack;
            bus.mem_rdata = 32'h5A5A_5A5A;
         end
      end
   end

   // Scoreboard and bus-stability monitor.
   logic [31:0] if_exp_q[$];
   logic [31:0] dm_exp_q[$];
   logic        prev_req;
   logic        prev_we;
   logic [31:0] prev_addr;
   logic [31:0] prev_wdata;
   initial begin
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_req = 1'b0;
         end else begin
            if (bus.if_done || bus.dm_done) begin
               chk("single_done", {31'b0, bus.if_done & bus.dm_done}, 32'd0);
            end
            if (bus.if_done) begin
               if (if_exp_q.size() == 0) begin
                  n_vec++; n_miss++;
                  $display("FAIL if_done_unexpected: got 1, want 0 (t=%0t)", $time);
               end else begin
                  chk("if_rdata", bus.if_rdata, if_exp_q.pop_front());
               end
            end
            if (bus.dm_done) begin
               if (dm_exp_q.size() == 0) begin
                  n_vec++; n_miss++;
                  $display("FAIL dm_done_unexpected: got 1, want 0 (t=%0t)", $time);
               end else begin
                  chk("dm_rdata", bus.dm_rdata, dm_exp_q.pop_front());
               end
            end
            if (bus.mem_req && prev_req) begin
               chk("mem_addr_stable", bus.mem_addr, prev_addr);
               chk("mem_we_stable", {31'b0, bus.mem_we}, {31'b0, prev_we});
               chk("mem_wdata_stable", bus.mem_wdata, prev_wdata);
            end
            prev_req   = bus.mem_req;
            prev_we    = bus.mem_we;
            prev_addr  = bus.mem_addr;
            prev_wdata = bus.mem_wdata;
         end
      end
   end

   typedef struct {
      bit          dm;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;     // 99 = never ack
      logic [31:0] exp_rdata;
      int          exp_done;  // cycle of done, request driven in cycle 0
      bit          exp_err;
   } vec_t;

   // Drives one access at posedge+1 (cycle 0) and follows it to its done pulse.
   task automatic run_vec(input vec_t v);
      bit got;
      got       = 0;
      resp_wait = v.waits;
      if (v.dm) begin
         bus.dm_req   = 1'b1;
         bus.dm_we    = v.we;
         bus.dm_addr  = v.addr;
         bus.dm_wdata = v.wdata;
         dm_exp_q.push_back(v.exp_rdata);
      end else begin
         bus.if_req  = 1'b1;
         bus.if_addr = v.addr;
         if_exp_q.push_back(v.exp_rdata);
      end
      #1;
      chk("stall_on_req", {31'b0, bus.stall}, 32'd1);
      for (int c = 1; c <= 40 && !got; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) begin
            chk("mem_req_c1", {31'b0, bus.mem_req}, 32'd1);
            chk("mem_addr_c1", bus.mem_addr, v.addr);
            chk("mem_we_c1", {31'b0, bus.mem_we}, {31'b0, v.dm & v.we});
            if (v.dm && v.we) chk("mem_wdata_c1", bus.mem_wdata, v.wdata);
         end
         if (v.dm ? bus.dm_done : bus.if_done) begin
            got = 1;
            chk("done_cycle", c, v.exp_done);
            chk("stall_in_done", {31'b0, bus.stall}, 32'd0);
            chk("err", {31'b0, err}, {31'b0, v.exp_err});
            chk("mem_req_in_done", {31'b0, bus.mem_req}, 32'd0);
            bus.if_req = 1'b0;
            bus.dm_req = 1'b0;
         end
      end
      if (!got) begin
         n_vec++; n_miss++;
         $display("FAIL done_timeout: got no done, want done at cycle %0d", v.exp_done);
         bus.if_req = 1'b0;
         bus.dm_req = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("done_pulse_width", {30'b0, bus.if_done, bus.dm_done}, 32'd0);
   endtask

   vec_t vecs[9];

   initial begin
      int n_dm, n_if, nd;
      vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,         0, 32'h8C22_0004,  2, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,         0, 32'hFEFF_0100,  2, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 3, 32'hFEFF_0100,  5, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 32'h80,  32'h0,         1, 32'hFF7F_0080,  3, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 32'h300, 32'h0,        14, 32'hFCFF_0300, 16, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 32'h44,  32'h0,        99, 32'hFFFF_FFFF, 16, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 32'h100, 32'h0,         0, 32'hFEFF_0100,  2, 1'b1};
      vecs[7] = '{1'b1, 1'b1, 32'h204, 32'h1234_5678, 99, 32'hFEFF_0100, 16, 1'b1};
      vecs[8] = '{1'b0, 1'b0, 32'h40,  32'h0,         2, 32'h8C22_0004,  4, 1'b1};

      reset        = 1'b1;
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.dm_req   = 1'b0;
      bus.dm_we    = 1'b0;
      bus.dm_addr  = '0;
      bus.dm_wdata = '0;
      #3;
      chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
      chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
      chk("rst_dones", {30'b0, bus.if_done, bus.dm_done}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_if_rdata", bus.if_rdata, 32'd0);
      chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
      chk("rst_stall", {31'b0, bus.stall}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i]);
      end

      // Simultaneous requests: dm wins, if granted from the done cycle's IDLE.
      resp_wait   = 0;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h80;
      bus.dm_req  = 1'b1;
      bus.dm_we   = 1'b0;
      bus.dm_addr = 32'h100;
      if_exp_q.push_back(32'hFF7F_0080);
      dm_exp_q.push_back(32'hFEFF_0100);
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk);
         #1;
         chk("simul_dm_done", {31'b0, bus.dm_done}, {31'b0, c == 2});
         chk("simul_if_done", {31'b0, bus.if_done}, {31'b0, c == 4});
         chk("simul_mem_req", {31'b0, bus.mem_req}, {31'b0, (c == 1) || (c == 3)});
         if (c == 1) chk("simul_grant1", bus.mem_addr, 32'h100);
         if (c == 3) chk("simul_grant2", bus.mem_addr, 32'h80);
         if (c == 2) chk("simul_stall_if_pending", {31'b0, bus.stall}, 32'd1);
         if (bus.dm_done) bus.dm_req = 1'b0;
         if (bus.if_done) bus.if_req = 1'b0;
      end

      // Fairness: both held high, completions must alternate dm, if, dm, if ...
      resp_wait   = 1;
      n_dm        = 0;
      n_if        = 0;
      nd          = 0;
      bus.dm_req  = 1'b1;
      bus.dm_addr = 32'h100;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h80;
      dm_exp_q.push_back(word_at(32'h100));
      if_exp_q.push_back(word_at(32'h80));
      for (int c = 1; c <= 60 && (bus.dm_req || bus.if_req); c++) begin
         @(posedge clk);
         #1;
         if (bus.dm_done) begin
            chk("fair_order_dm", nd % 2, 0);
            nd++;
            n_dm++;
            if (n_dm < 3) begin
               bus.dm_addr = 32'h100 + 32'(4 * n_dm);
               dm_exp_q.push_back(word_at(bus.dm_addr));
            end else begin
               bus.dm_req = 1'b0;
            end
         end
         if (bus.if_done) begin
            chk("fair_order_if", nd % 2, 1);
            nd++;
            n_if++;
            if (n_if < 3) begin
               bus.if_addr = 32'h80 + 32'(4 * n_if);
               if_exp_q.push_back(word_at(bus.if_addr));
            end else begin
               bus.if_req = 1'b0;
            end
         end
      end
      chk("fair_done_count", nd, 6);
      bus.dm_req = 1'b0;
      bus.if_req = 1'b0;
      @(posedge clk);
      #1;

      // mem_ack while idle must be ignored.
      idle_ack = 1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("idle_ack_dones", {30'b0, bus.if_done, bus.dm_done}, 32'd0);
         chk("idle_ack_mem_req", {31'b0, bus.mem_req}, 32'd0);
      end
      chk("idle_ack_if_rdata", bus.if_rdata, word_at(32'h88));
      idle_ack = 0;

      // Reset mid-access: store stuck in SERVE_DM, then asynchronous reset.
      resp_wait    = 1000;
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'b1;
      bus.dm_addr  = 32'h208;
      bus.dm_wdata = 32'hCAFE_F00D;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_mem_req", {31'b0, bus.mem_req}, 32'd1);
      chk("pre_rst_err", {31'b0, err}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
      chk("async_rst_dm_done", {31'b0, bus.dm_done}, 32'd0);
      chk("async_rst_err", {31'b0, err}, 32'd0);
      chk("async_rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
      bus.dm_req = 1'b0;
      bus.dm_we  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("post_rst_no_done", {30'b0, bus.if_done, bus.dm_done}, 32'd0);
         chk("post_rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
      end
      run_vec('{1'b0, 1'b0, 32'h40, 32'h0, 0, 32'h8C22_0004, 2, 1'b0});

      repeat (2) @(posedge clk);
      chk("if_queue_drained", if_exp_q.size(), 0);
      chk("dm_queue_drained", dm_exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
